ntsc_sync_sep: RTL and testbench
================================

NTSC_SYNC_SEP -- requirements
Module: ntsc_sync_sep

Interface
REQ-001 SHALL have parameter C_SLICE, default 9'd64: sync slice level; a sample below it is sync tip.
REQ-002 SHALL have parameter C_HS_MIN, default 50: minimum width, in samples, of a valid hsync pulse.
REQ-003 SHALL have parameter C_HS_MAX, default 90: maximum width, in samples, of a valid hsync pulse.
REQ-004 SHALL have parameter C_BROAD_MIN, default 300: minimum width, in samples, of a vertical broad pulse.
REQ-005 SHALL have parameter C_H_TOL, default 4: tolerance, in samples, on the hsync arrival window.
REQ-006 SHALL have port CK_i, input, 1 bit: the single clock.
REQ-007 SHALL have port XAR_i, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port CK_EE_i, input, 1 bit: 4fsc sample enable; all state advances only when it is 1.
REQ-009 SHALL have port VIDEOs_i, input, 9 bits: unsigned composite sample; sync tip is low.
REQ-010 SHALL have port XHD_o, output, 1 bit: regenerated horizontal drive, 0 for one sample.
REQ-011 SHALL have port XVD_o, output, 1 bit: regenerated vertical drive, 0 for one sample.
REQ-012 SHALL have ports HCTRs_o and VCTRs_o, outputs, 10 bits each: sample count within the line (0..909) and line count (0..524).
REQ-013 SHALL have port LOCK_o, output, 1 bit: 1 when horizontal lock is achieved.
REQ-014 SHALL have port FIELD_o, output, 1 bit: 0 for odd field, 1 for even field.

Function
REQ-015 SHALL register SYNC = (VIDEOs_i < C_SLICE), then derive SYNC_FALL and SYNC_RISE edges.
REQ-016 SHALL count the sync width from SYNC_FALL; the counter saturates at 511.
REQ-017 SHALL classify the pulse at SYNC_RISE: width in [C_HS_MIN,C_HS_MAX] gives HS; width >= C_BROAD_MIN gives BROAD; any other width gives EQ/ignored.
REQ-018 SHALL run HCTR freely with wrap at 909->0.
REQ-019 SHALL treat an HS pulse as "good" when its SYNC_FALL occurs with HCTR in 909-C_H_TOL..909 or 0..C_H_TOL.
REQ-020 SHALL implement a lock FSM with states SEARCH, TRACK and LOCK.
REQ-021 In SEARCH, any HS SHALL reload HCTR to 0 at its SYNC_FALL sample (retroactive: HCTR=width at RISE) and move the FSM to TRACK.
REQ-022 In TRACK, 8 consecutive good HS SHALL move the FSM to LOCK; a bad HS SHALL return it to SEARCH.
REQ-023 In LOCK, HCTR SHALL NOT be reloaded and SHALL flywheel; 4 consecutive lines without a good HS SHALL move the FSM to SEARCH.
REQ-024 SHALL hold LOCK_o at 1 only in state LOCK.
REQ-025 SHALL drive XHD_o to 0 for the sample where HCTR==909, with 1-sample registered latency.
REQ-026 SHALL increment VCTR when HCTR wraps, with wrap at 524->0.
REQ-027 On the 3rd consecutive BROAD pulse, SHALL set VCTR to 3 at the next HCTR wrap and drive XVD_o to 0 for the sample where VCTR==0 and HCTR==909.
REQ-028 SHALL set FIELD_o at the 1st BROAD pulse: 0 if its SYNC_FALL occurs with HCTR<455, 1 otherwise.
REQ-029 SHALL update FIELD_o only on a BROAD sequence.
REQ-030 When SYNC_FALL and an HCTR wrap coincide, the reload SHALL win; VCTR increments exactly once.
REQ-031 When no video is present (SYNC stuck at 1, width saturated), SHALL classify nothing and drop LOCK after 4 lines.
REQ-032 When CK_EE_i=0, SHALL hold all state and outputs.

Reset
REQ-033 On XAR_i=0, SHALL asynchronously set XHD_o=1, XVD_o=1, HCTRs_o=0, VCTRs_o=0, LOCK_o=0, FIELD_o=0, the FSM to SEARCH, and all counters and the BROAD count to 0.
REQ-034 Reset mid-line SHALL discard the partial pulse; the first SYNC_FALL after release starts a new measurement.

Configuration
REQ-035 With NTSC_SYNC_SEP_GLITCH_FILT_EN defined, SYNC SHALL be the 3-sample majority of the slice result; this adds 1 sample of latency, compensated by HCTR reload to 1.
REQ-036 Without NTSC_SYNC_SEP_GLITCH_FILT_EN, SYNC SHALL be the raw registered slice.

Structure
REQ-037 Constants C_H_TOTAL=910, C_V_TOTAL=525, C_H_HALF=455, the pulse-class encoding and the FSM state encoding SHALL live in shared package ntsc_pkg.
REQ-038 Slicing, width counting and classification SHALL be sub-module ntsc_sync_pulse_class; line/field timing and the FSM SHALL stay in the top.

Verification
REQ-039 Drive ntsc_tg+ntsc_mod output into VIDEOs_i with CK_EE every 4 clocks -> LOCK_o=1 by line 10; XHD_o low exactly every 910 enabled samples.
REQ-040 Feed 3 broad pulses of 387 samples starting at HCTR 0 -> FIELD_o=0, and XVD_o low once 525 lines apart in steady state.
REQ-041 Feed broad pulses starting at HCTR 455 -> FIELD_o=1.
REQ-042 Shift hsync +20 samples while locked -> HCTR flywheels; after 4 lines LOCK_o=0; relock within 9 lines.
REQ-043 Inject a single-sample dip below C_SLICE mid-line -> with the _EN macro, no effect; without it, the pulse is ignored as EQ and LOCK is held.
REQ-044 Assert XAR_i mid-broad-pulse -> all outputs take reset values immediately; after release and 20 clean lines, LOCK_o=1.

Source files
------------

// File: rtl/ntsc_pkg.sv
// ntsc_pkg: shared NTSC line/field constants, sync pulse classes and lock-FSM states
package ntsc_pkg;
  localparam int C_H_TOTAL = 910;
  localparam int C_V_TOTAL = 525;
  localparam int C_H_HALF  = 455;
  typedef enum logic [1:0] {PC_NONE, PC_HS, PC_BROAD, PC_EQ} pulse_e;
  typedef enum logic [1:0] {ST_SEARCH, ST_TRACK, ST_LOCK} lock_e;
endpackage

// File: rtl/ntsc_sync_pulse_class.sv
// ntsc_sync_pulse_class: slices composite video, measures sync-tip width, classifies each pulse
//   clk_i/rst_ni/ce_i : clock, async active-low reset, sample enable
//   video_i           : unsigned composite sample
//   fall_o            : one-sample strobe on the first sync-tip sample
//   cls_o / width_o   : pulse class and width, cls_o valid (not PC_NONE) only on the rise sample
//   NTSC_SYNC_SEP_GLITCH_FILT_EN : 3-sample majority filter on the slice (adds 1 sample latency)
module ntsc_sync_pulse_class
  import ntsc_pkg::*;
#(
  parameter logic [8:0] C_SLICE     = 9'd64,
  parameter int         C_HS_MIN    = 50,
  parameter int         C_HS_MAX    = 90,
  parameter int         C_BROAD_MIN = 300
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic [8:0] video_i,
  output logic       fall_o,
  output pulse_e     cls_o,
  output logic [8:0] width_o
);
  logic       slice, sync_d, sync_q, prev_q, rise;
  logic [8:0] wid_q, wid_d;
  assign slice = video_i < C_SLICE;
`ifdef NTSC_SYNC_SEP_GLITCH_FILT_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) hist_q <= '0;
    else if (ce_i) hist_q <= {hist_q[0], slice};
  assign sync_d = (slice & hist_q[0]) | (slice & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sync_d = slice;
`endif
  assign fall_o  = sync_q & ~prev_q;
  assign rise    = ~sync_q & prev_q;
  assign width_o = wid_q;
  // the fall sample itself counts as the first sample of the pulse
  assign wid_d = fall_o ? 9'd1 : (sync_q && wid_q != 9'd511) ? wid_q + 9'd1 : wid_q;
  assign cls_o = !rise ? PC_NONE :
                 (wid_q >= 9'(C_HS_MIN) && wid_q <= 9'(C_HS_MAX)) ? PC_HS :
                 wid_q >= 9'(C_BROAD_MIN) ? PC_BROAD : PC_EQ;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      wid_q  <= '0;
    end else if (ce_i) begin
      sync_q <= sync_d;
      prev_q <= sync_q;
      wid_q  <= wid_d;
    end
endmodule

// File: rtl/ntsc_sync_sep.sv
// ntsc_sync_sep: NTSC sync separator with horizontal lock FSM, line/field counters and HD/VD regeneration
//   CK_i/XAR_i/CK_EE_i : clock, async active-low reset, 4fsc sample enable
//   VIDEOs_i           : unsigned composite sample, sync tip low
//   XHD_o/XVD_o        : active-low one-sample horizontal/vertical drive
//   HCTRs_o/VCTRs_o    : sample-in-line (0..909) and line (0..524) counters
//   LOCK_o/FIELD_o     : horizontal lock, field (0 odd, 1 even)
//   NTSC_SYNC_SEP_GLITCH_FILT_EN : enables the majority glitch filter in the slicer
module ntsc_sync_sep
  import ntsc_pkg::*;
#(
  parameter logic [8:0] C_SLICE     = 9'd64,
  parameter int         C_HS_MIN    = 50,
  parameter int         C_HS_MAX    = 90,
  parameter int         C_BROAD_MIN = 300,
  parameter int         C_H_TOL     = 4
) (
  input  logic       CK_i,
  input  logic       XAR_i,
  input  logic       CK_EE_i,
  input  logic [8:0] VIDEOs_i,
  output logic       XHD_o,
  output logic       XVD_o,
  output logic [9:0] HCTRs_o,
  output logic [9:0] VCTRs_o,
  output logic       LOCK_o,
  output logic       FIELD_o
);
  // reload lands one sample after the rise as if HCTR had been 0 at the fall;
  // the filter delays fall and rise by one more sample
`ifdef NTSC_SYNC_SEP_GLITCH_FILT_EN
  localparam logic [9:0] RELOAD = 10'd2;
`else
  localparam logic [9:0] RELOAD = 10'd1;
`endif
  localparam logic [9:0] H_LAST = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(C_V_TOTAL - 1);
  localparam logic [9:0] H_HALF = 10'(C_H_HALF);
  localparam logic [9:0] WIN_LO = 10'(C_H_TOTAL - 1 - C_H_TOL);
  localparam logic [9:0] WIN_HI = 10'(C_H_TOL);
  logic       fall, wrap, hs, broad, good;
  pulse_e     cls;
  logic [8:0] wid;
  lock_e      state_q, state_d;
  logic [9:0] hctr_q, hctr_d, vctr_q, vctr_d, fall_h_q, fall_h_d;
  logic [2:0] tcnt_q, tcnt_d, miss_q, miss_d;
  logic [1:0] bc_q, bc_d;
  logic       seen_q, seen_d, vpend_q, vpend_d, field_q, field_d, xhd_q, xhd_d, xvd_q, xvd_d;
  ntsc_sync_pulse_class #(
    .C_SLICE(C_SLICE), .C_HS_MIN(C_HS_MIN), .C_HS_MAX(C_HS_MAX), .C_BROAD_MIN(C_BROAD_MIN)
  ) u_pc (
    .clk_i(CK_i), .rst_ni(XAR_i), .ce_i(CK_EE_i), .video_i(VIDEOs_i),
    .fall_o(fall), .cls_o(cls), .width_o(wid)
  );
  assign wrap  = hctr_q == H_LAST;
  assign hs    = cls == PC_HS;
  assign broad = cls == PC_BROAD;
  assign good  = hs && (fall_h_q >= WIN_LO || fall_h_q <= WIN_HI);
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    // a line "misses" when it wraps without a good HS having been seen since the last wrap
    miss_d  = state_q != ST_LOCK ? 3'd0 : !wrap ? miss_q : (seen_q || good) ? 3'd0 : miss_q + 3'd1;
    case (state_q)
      ST_SEARCH: if (hs) begin
        state_d = ST_TRACK;
        tcnt_d  = 3'd0;
      end
      ST_TRACK: if (hs) begin
        state_d = !good ? ST_SEARCH : tcnt_q == 3'd7 ? ST_LOCK : ST_TRACK;
        tcnt_d  = tcnt_q + 3'd1;
      end
      default: if (wrap && !(seen_q || good) && miss_q == 3'd3) state_d = ST_SEARCH;
    endcase
    // a reload and a natural wrap never both count: VCTR follows only the wrap
    hctr_d   = (hs && state_q != ST_LOCK) ? {1'b0, wid} + RELOAD : wrap ? 10'd0 : hctr_q + 10'd1;
    vctr_d   = !wrap ? vctr_q : vpend_q ? 10'd3 : vctr_q == V_LAST ? 10'd0 : vctr_q + 10'd1;
    fall_h_d = fall ? hctr_q : fall_h_q;
    seen_d   = good || (seen_q && !wrap);
    bc_d     = broad ? (bc_q == 2'd3 ? 2'd3 : bc_q + 2'd1) : hs ? 2'd0 : bc_q;
    vpend_d  = (broad && bc_q == 2'd2) || (vpend_q && !wrap);
    field_d  = (broad && bc_q == 2'd0) ? fall_h_q >= H_HALF : field_q;
    xhd_d    = !wrap;
    xvd_d    = !(wrap && vctr_q == 10'd0);
  end
  always_ff @(posedge CK_i or negedge XAR_i)
    if (!XAR_i) begin
      state_q  <= ST_SEARCH;
      hctr_q   <= '0;
      vctr_q   <= '0;
      fall_h_q <= '0;
      tcnt_q   <= '0;
      miss_q   <= '0;
      bc_q     <= '0;
      seen_q   <= 1'b0;
      vpend_q  <= 1'b0;
      field_q  <= 1'b0;
      xhd_q    <= 1'b1;
      xvd_q    <= 1'b1;
    end else if (CK_EE_i) begin
      state_q  <= state_d;
      hctr_q   <= hctr_d;
      vctr_q   <= vctr_d;
      fall_h_q <= fall_h_d;
      tcnt_q   <= tcnt_d;
      miss_q   <= miss_d;
      bc_q     <= bc_d;
      seen_q   <= seen_d;
      vpend_q  <= vpend_d;
      field_q  <= field_d;
      xhd_q    <= xhd_d;
      xvd_q    <= xvd_d;
    end
  assign XHD_o   = xhd_q;
  assign XVD_o   = xvd_q;
  assign HCTRs_o = hctr_q;
  assign VCTRs_o = vctr_q;
  assign LOCK_o  = state_q == ST_LOCK;
  assign FIELD_o = field_q;
endmodule

// File: tb/tb_ntsc_sync_sep.sv
// tb_ntsc_sync_sep: directed self-checking bench for ntsc_sync_sep
module tb_ntsc_sync_sep;
  logic       CK_i = 1'b0;
  logic       XAR_i = 1'b1;
  logic       CK_EE_i = 1'b1;
  logic [8:0] VIDEOs_i = 9'd64;
  logic       XHD_o, XVD_o, LOCK_o, FIELD_o;
  logic [9:0] HCTRs_o, VCTRs_o;
  int ntests = 0;
  int nfail = 0;
  int ln = 0;
  always #5 CK_i = ~CK_i;
  ntsc_sync_sep dut (
    .CK_i(CK_i), .XAR_i(XAR_i), .CK_EE_i(CK_EE_i), .VIDEOs_i(VIDEOs_i),
    .XHD_o(XHD_o), .XVD_o(XVD_o), .HCTRs_o(HCTRs_o), .VCTRs_o(VCTRs_o),
    .LOCK_o(LOCK_o), .FIELD_o(FIELD_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s (line %0d): got %0d expected %0d", tag, ln, obs, exp);
    end
  endtask
  // 63 is just below the slice level, 64 exactly at it (not sync)
  task automatic put(input bit lo);
    VIDEOs_i = lo ? 9'd63 : 9'd64;
    @(posedge CK_i);
    #1;
  endtask
  // one 910-sample line: tip over [st, st+len) plus optional one-sample dip at dip;
  // xexp = sample where XHD_o must be low (-1: never low), vexp = XVD_o low count
  task automatic line(input int st, input int len, input int dip, input int xexp, input int vexp);
    int xl, xp, vl;
    xl = 0;
    xp = -1;
    vl = 0;
    ln++;
    for (int s = 0; s < 910; s++) begin
      put((s >= st && s < st + len) || s == dip);
      if (XHD_o === 1'b0) begin
        xl++;
        xp = s;
      end
      if (XVD_o === 1'b0) vl++;
    end
    chk("xhd_count", xl, xexp < 0 ? 0 : 1);
    if (xexp >= 0) chk("xhd_pos", xp, xexp);
    chk("xvd_count", vl, vexp);
  endtask
  task automatic chk_reset();
    chk("rst_xhd", XHD_o, 1);
    chk("rst_xvd", XVD_o, 1);
    chk("rst_hctr", HCTRs_o, 0);
    chk("rst_vctr", VCTRs_o, 0);
    chk("rst_lock", LOCK_o, 0);
    chk("rst_field", FIELD_o, 0);
  endtask
  initial begin
    #2 XAR_i = 1'b0;
    repeat (3) @(posedge CK_i);
    #1;
    chk_reset();
    XAR_i = 1'b1;
    // acquisition: lock on the 9th HS
    line(0, 67, -1, -1, 0);
    line(0, 67, -1, 0, 1);
    repeat (6) line(0, 67, -1, 0, 0);
    chk("lock_l8", LOCK_o, 0);
    chk("vctr_l8", VCTRs_o, 7);
    line(0, 67, -1, 0, 0);
    chk("lock_l9", LOCK_o, 1);
    chk("vctr_l9", VCTRs_o, 8);
    chk("hctr_l9", HCTRs_o, 909);
    line(0, 67, -1, 0, 0);
    // sample enable low: everything frozen even with sync-tip video
    CK_EE_i = 1'b0;
    repeat (20) put(1'b1);
    chk("hold_hctr", HCTRs_o, 909);
    chk("hold_vctr", VCTRs_o, 9);
    chk("hold_xhd", XHD_o, 1);
    chk("hold_lock", LOCK_o, 1);
    CK_EE_i = 1'b1;
    // single-sample dip mid-line is not an HS
    line(0, 67, 400, 0, 0);
    chk("glitch_lock", LOCK_o, 1);
    chk("glitch_hctr", HCTRs_o, 909);
    chk("glitch_vctr", VCTRs_o, 10);
    // broad pulses falling at HCTR 455 -> even field, VCTR=3 after the 3rd
    line(455, 387, -1, 0, 0);
    chk("field_even", FIELD_o, 1);
    line(455, 387, -1, 0, 0);
    line(455, 387, -1, 0, 0);
    chk("vctr_b3", VCTRs_o, 13);
    line(0, 67, -1, 0, 0);
    chk("vsync_vctr", VCTRs_o, 3);
    chk("vsync_lock", LOCK_o, 1);
    chk("vsync_field", FIELD_o, 1);
    line(0, 67, -1, 0, 0);
    // broad pulses falling at HCTR 0 -> odd field
    line(0, 387, -1, 0, 0);
    chk("field_odd", FIELD_o, 0);
    line(0, 387, -1, 0, 0);
    line(0, 387, -1, 0, 0);
    chk("vctr_b3b", VCTRs_o, 7);
    line(0, 67, -1, 0, 0);
    chk("vsync2_vctr", VCTRs_o, 3);
    chk("vsync2_lock", LOCK_o, 1);
    // hsync moved +20: flywheel for 4 lines, then search and relock
    repeat (4) line(20, 67, -1, 0, 0);
    chk("fly_lock", LOCK_o, 1);
    chk("fly_hctr", HCTRs_o, 909);
    line(20, 67, -1, 0, 0);
    chk("lost_lock", LOCK_o, 0);
    repeat (7) line(20, 67, -1, 20, 0);
    chk("relock_l8", LOCK_o, 0);
    line(20, 67, -1, 20, 0);
    chk("relock_lock", LOCK_o, 1);
    chk("relock_hctr", HCTRs_o, 889);
    chk("relock_vctr", VCTRs_o, 16);
    // broad pulse at HCTR 455 of the shifted timing sets the even field
    line(475, 387, -1, 20, 0);
    chk("field_even2", FIELD_o, 1);
    // reset in the middle of a broad pulse
    ln++;
    for (int s = 0; s <= 600; s++) put(s >= 475);
    XAR_i = 1'b0;
    #1;
    chk_reset();
    VIDEOs_i = 9'd64;
    repeat (3) @(posedge CK_i);
    #1;
    XAR_i = 1'b1;
    line(0, 67, -1, -1, 0);
    line(0, 67, -1, 0, 1);
    repeat (18) line(0, 67, -1, 0, 0);
    chk("post_rst_lock", LOCK_o, 1);
    chk("post_rst_hctr", HCTRs_o, 909);
    chk("post_rst_vctr", VCTRs_o, 19);
    // no video: sync stuck, nothing classified, lock dropped after 4 lines
    repeat (4) line(0, 910, -1, 0, 0);
    chk("novid_lock4", LOCK_o, 1);
    put(1'b1);
    chk("novid_lock", LOCK_o, 0);
    chk("novid_hctr", HCTRs_o, 0);
    chk("novid_vctr", VCTRs_o, 24);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
